// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: program counter owner and instruction fetch front end.
// Issues one instruction-memory word read at a time. Each returned word is
// presented to decode, together with its PC, through a valid/ready output
// register. An execute-stage redirect flushes the stage, including any
// memory response that is still in flight.
// Optional feature macro: FETCH_PERF_CNT_EN adds the perf_fetched and
// perf_stall saturating counters.
module instr_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned IMEM_AW  = 64
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [63:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_pc,
  output logic [31:0]        out_instruction
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // ready to issue a request when the output slot frees up
    S_WAIT  = 2'd1,  // request outstanding, response goes to decode
    S_DROP  = 2'd2   // request outstanding but flushed, response is discarded
  } state_e;

  state_e             state_q;
  logic [63:0]        pc_q, pc_d;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic               out_valid_q;
  logic [63:0]        out_pc_q;
  logic [31:0]        out_instr_q;

  logic [63:0] redirect_pc_aligned;
  logic        transfer;
  logic        slot_free;

  assign redirect_pc_aligned = redirect_pc & ~64'h3;
  assign transfer            = out_valid_q & out_ready;
  assign slot_free           = ~out_valid_q | out_ready;

  // Request only when the output register is empty by the time the
  // response lands; held low while reset is asserted.
  assign imem_req = ~reset & (state_q == S_FETCH) & ~redirect & slot_free;

  // Next PC: redirect wins, otherwise advance when a response is accepted.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc_aligned;
    end else if (state_q == S_WAIT && imem_valid) begin
      pc_d = pc_q + 64'd4;
    end
  end

  // Fetch FSM together with the PC, request address and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      imem_addr_q <= RESET_PC[IMEM_AW-1:0];
      out_valid_q <= 1'b0;
      out_pc_q    <= 64'h0;
      out_instr_q <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      imem_addr_q <= pc_d[IMEM_AW-1:0];
      if (transfer) begin
        out_valid_q <= 1'b0;
      end
      if (redirect) begin
        out_valid_q <= 1'b0;
        // An outstanding request must still be drained unless its
        // response is arriving right now.
        if (state_q != S_FETCH) begin
          state_q <= imem_valid ? S_FETCH : S_DROP;
        end else begin
          state_q <= S_FETCH;
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (imem_req) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_valid) begin
              out_pc_q    <= pc_q;
              out_instr_q <= imem_rdata;
              out_valid_q <= 1'b1;
              state_q     <= S_FETCH;
            end
          end
          S_DROP: begin
            if (imem_valid) begin
              state_q <= S_FETCH;
            end
          end
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

  assign imem_addr       = imem_addr_q;
  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_instruction = out_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Saturating counts of decode transfers and backpressure cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      if (transfer && perf_fetched_q != 32'hFFFF_FFFF) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (out_valid_q && !out_ready && perf_stall_q != 32'hFFFF_FFFF) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage that sits directly upstream of the RISC_V_Processor datapath's decode logic. It owns the 64-bit program counter and issues word reads to instruction memory with one request outstanding at a time. It presents each fetched instruction and its PC to decode through a valid/ready register. Branch redirects from execute flush the stage, including any in-flight memory response.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `IMEM_AW`, default 64: instruction address width.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `imem_req` output 1: one-cycle request strobe to instruction memory.
- `imem_addr` output IMEM_AW: word address of the request; bits [1:0] always 0.
- `imem_valid` input 1: response strobe; arrives ≥1 cycle after `imem_req`.
- `imem_rdata` input 32: instruction word; valid while `imem_valid`=1.
- `redirect` input 1: branch/jump taken in execute.
- `redirect_pc` input 64: new PC; bits [1:0] are ignored and forced to 0.
- `out_valid` output 1: instruction register holds a valid instruction for decode.
- `out_ready` input 1: decode accepts the instruction this cycle.
- `out_pc` output 64: PC of the presented instruction.
- `out_instruction` output 32: presented instruction word.

## Operation
- FSM states: FETCH, WAIT, DROP.
- In FETCH, `imem_req`=1 when `redirect`=0 and (`out_valid`=0 or `out_ready`=1).
  - `imem_addr`=pc.
  - Next state is WAIT.
- In WAIT, when `imem_valid`=1 and `redirect`=0:
  - `out_pc`←pc, `out_instruction`←`imem_rdata`, `out_valid`←1.
  - pc←pc+4, with 64-bit modulo wrap (FFFF_FFFF_FFFF_FFFC+4 = 0).
  - Next state is FETCH.
- In WAIT with `redirect`=1 and `imem_valid`=0: pc←`redirect_pc`, next state is DROP.
- In WAIT with `redirect`=1 and `imem_valid`=1 in the same cycle: the response is discarded, pc←`redirect_pc`, next state is FETCH.
- In DROP, the next `imem_valid` is discarded and the state returns to FETCH.
  - `redirect` in DROP updates pc and the state stays DROP.
- In FETCH with `redirect`=1: pc←`redirect_pc`, no request is issued that cycle.
- In any state, `redirect`=1 clears `out_valid` on the next edge; redirect takes priority over the handshake.
- Handshake rules:
  - A transfer occurs when `out_valid`=1 and `out_ready`=1.
  - While `out_valid`=1 and `out_ready`=0, `out_pc` and `out_instruction` hold stable.
  - A transfer with no new load clears `out_valid`.
- The slot-free issue rule guarantees the output register is empty when a response lands, so no response is ever lost.
- `imem_valid` in FETCH is a protocol error and is ignored.

## Timing
- Reset values:
  - state FETCH, pc `RESET_PC`, `imem_req` 0, `imem_addr` `RESET_PC`.
  - `out_valid` 0, `out_pc` 0, `out_instruction` 0.
  - Performance counters 0.
- Reset asserted mid-WAIT or mid-DROP: the stage returns to FETCH immediately. A later stray `imem_valid` is ignored because the state is FETCH.
- `imem_req` is asserted in the first cycle after reset deasserts.
- Latency: the response edge sets `out_valid`, so the instruction is visible to decode the cycle after `imem_valid`.
- Peak throughput is 1 instruction per 2 cycles with 1-cycle memory latency; with N-cycle latency it is 1 per N+1 cycles.
- After a redirect with the stage in FETCH, the first request to `redirect_pc` goes out on the following cycle.
- All outputs are registered except `imem_req`, which is decoded combinationally from state, `out_valid`, `out_ready` and `redirect`.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds outputs `perf_fetched` [31:0] and `perf_stall` [31:0].
  - `perf_fetched` increments on every accepted decode transfer.
  - `perf_stall` increments every cycle with `out_valid`=1 and `out_ready`=0.
  - Both counters saturate at FFFF_FFFF and reset to 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset release, `RESET_PC`=0, memory latency 1, `out_ready`=1:
  - `imem_addr` sequence is 0,4,8,C.
  - `out_pc`/`out_instruction` follow with `out_valid` pulsing every other cycle.
- Backpressure: `out_ready`=0 for 5 cycles with the instruction 0x00500093 at PC 8:
  - Outputs hold 8/0x00500093.
  - No `imem_req` is issued.
  - `perf_stall`=5 when `FETCH_PERF_CNT_EN` is defined.
- Redirect in WAIT, latency 3: `redirect`=1, `redirect_pc`=0x100 one cycle after a request to 0x10.
  - The 0x10 response is dropped and never appears on `out_*`.
  - The next `imem_addr` is 0x100.
- Redirect coincident with `imem_valid`, `redirect_pc`=0x203:
  - The response is discarded and `out_valid`=0.
  - The next request goes to 0x200.
- Reset mid-WAIT, then a stray `imem_valid` after release:
  - It is ignored.
  - The first `out_pc` is `RESET_PC`.
- Wrap: `redirect_pc`=FFFF_FFFF_FFFF_FFFC; the next request after that fetch is address 0.
